imem_loader: RTL and testbench

Byte-stream loader that fills the 8KB 4-way instruction memory before the core runs. Sits directly upstream of the writable instruction memory: accepts bytes over a valid/ready handshake from the host link (UART receiver), packs 16 bytes into one 128-bit line, and drives one write per line on the memory's addr/wdata/we port. Reports busy/done and, optionally, a checksum error.

---
 rtl/imem_loader.sv | 157 +++++++++++++++
 tb/tb_imem_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: packs a valid/ready byte stream into 128-bit lines and writes
// them into the instruction memory, one write strobe per line.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing 32-bit
// little-endian checksum check against the wraparound sum of all words.
module imem_loader (
  input  logic         clk,
  input  logic         reset_x,
  input  logic         start,
  input  logic [9:0]   len_lines,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [8:0]   imem_addr,
  output logic [127:0] imem_wdata,
  output logic         imem_we,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned NLINES  = 512;
  localparam int unsigned LEN_W   = 10;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned BCNT_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   line_cnt;
  logic [LEN_W-1:0]   line_cnt_inc;
  logic [BCNT_W-1:0]  byte_cnt;
  logic [LEN_W-1:0]   len_clamped;

  // Requested line count saturated at the memory depth
  assign len_clamped  = (len_lines > LEN_W'(NLINES)) ? LEN_W'(NLINES) : len_lines;
  assign line_cnt_inc = line_cnt + LEN_W'(1);

  // Handshake and status strobes decoded straight from the state register
  assign imem_we = (state == S_WRITE);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign in_ready = (state == S_RECV) || (state == S_CSUM);
  assign busy     = (state == S_RECV) || (state == S_WRITE) || (state == S_CSUM);
`else
  assign in_ready = (state == S_RECV);
  assign busy     = (state == S_RECV) || (state == S_WRITE);
  assign err      = 1'b0;
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum;
  logic [31:0] rx_sum;
  logic [31:0] line_sum;

  // Sum of the four instruction words in the line being written
  assign line_sum = imem_wdata[31:0] + imem_wdata[63:32]
                  + imem_wdata[95:64] + imem_wdata[127:96];
`endif

  // Loader FSM with registered address, line data, done and error flags
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state      <= S_IDLE;
      len_q      <= '0;
      line_cnt   <= '0;
      byte_cnt   <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      err        <= 1'b0;
      sum        <= '0;
      rx_sum     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            len_q     <= len_clamped;
            line_cnt  <= '0;
            byte_cnt  <= '0;
            imem_addr <= '0;
            done      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            err       <= 1'b0;
            sum       <= '0;
`endif
            if (len_clamped == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= S_CSUM;
`else
              state <= S_DONE;
              done  <= 1'b1;
`endif
            end else begin
              state <= S_RECV;
            end
          end
        end

        S_RECV: begin
          if (in_valid) begin
            imem_wdata[{byte_cnt, 3'b000} +: 8] <= in_data;
            byte_cnt <= byte_cnt + BCNT_W'(1);
            if (byte_cnt == BCNT_W'(15)) begin
              state <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          line_cnt  <= line_cnt_inc;
          imem_addr <= ADDR_W'(line_cnt_inc);
          byte_cnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum       <= sum + line_sum;
`endif
          if (line_cnt_inc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state <= S_CSUM;
`else
            state <= S_DONE;
            done  <= 1'b1;
`endif
          end else begin
            state <= S_RECV;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (in_valid) begin
            rx_sum[{byte_cnt[1:0], 3'b000} +: 8] <= in_data;
            byte_cnt <= byte_cnt + BCNT_W'(1);
            if (byte_cnt == BCNT_W'(3)) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= ({in_data, rx_sum[23:0]} != sum);
            end
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized byte-stream loads checked cycle by cycle against
// a behavioural model of the loader's externally visible timing and writes.
module tb_imem_loader;

  logic         clk = 1'b0;
  logic         reset_x = 1'b0;
  logic         start = 1'b0;
  logic [9:0]   len_lines = '0;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [8:0]   imem_addr;
  logic [127:0] imem_wdata;
  logic         imem_we;
  logic         busy;
  logic         done;
  logic         err;

  imem_loader dut (
    .clk        (clk),
    .reset_x    (reset_x),
    .start      (start),
    .len_lines  (len_lines),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_we    (imem_we),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef struct {
    logic [8:0]   addr;
    logic [127:0] data;
  } wr_t;

  int           checks = 0;
  int           errors = 0;
  bit           chk_en = 1'b0;
  logic         e_busy = 1'b0, e_ready = 1'b0, e_we = 1'b0, e_done = 1'b0, e_err = 1'b0;
  wr_t          exp_q[$];
  int           n_writes = 0;
  int           busy_cycles = 0;
  logic [8:0]   last_addr = '0;
  logic [127:0] last_data = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model expectations
  always @(negedge clk) begin
    if (chk_en && reset_x) begin
      check("in_ready", in_ready, e_ready);
      check("busy", busy, e_busy);
      check("imem_we", imem_we, e_we);
      check("done", done, e_done);
      if (e_done) check("err", err, e_err);
      if (busy) busy_cycles++;
      if (imem_we) begin
        n_writes++;
        last_addr = imem_addr;
        last_data = imem_wdata;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h with no write pending", imem_addr);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          check("wr_addr", imem_addr, w.addr);
          check("wr_data", imem_wdata, w.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Offer one byte, inserting random idle cycles, until the model says it was taken
  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc) begin
      if (int'($urandom_range(99)) < gap) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
      end
      if (poke && tries == 0) begin
        start     = 1'b1;
        len_lines = 10'd0;
      end
      acc = in_valid;
      cyc();
      start = 1'b0;
      in_valid = 1'b0;
      tries++;
      if (tries > 1000) begin
        $display("FAIL send_byte_timeout: byte %0h never accepted", b);
        $fatal(1, "send_byte timeout");
      end
    end
  endtask

  // One complete load: builds the byte stream, predicts writes/sum, drives it
  task automatic do_load(input int len, input int gap, input int mode, input bit bad_tr,
                         input int abort_at, input int poke_at);
    logic [7:0]   bytes[$];
    logic [31:0]  sum;
    logic [31:0]  tr;
    logic [31:0]  w;
    logic [127:0] line;
    int           eff;
    eff = (len > 512) ? 512 : len;
    sum = '0;
    for (int i = 0; i < eff * 16; i++) begin
      case (mode)
        1:       bytes.push_back(8'(i));
        2:       bytes.push_back((i == 0) ? 8'h78 : (i == 1) ? 8'h56 :
                                 (i == 2) ? 8'h34 : (i == 3) ? 8'h12 : 8'h00);
        default: bytes.push_back(8'($urandom));
      endcase
    end
    for (int j = 0; j < eff * 4; j++) begin
      w   = {bytes[4*j+3], bytes[4*j+2], bytes[4*j+1], bytes[4*j]};
      sum = sum + w;
    end
    for (int l = 0; l < eff; l++) begin
      wr_t e;
      line = '0;
      for (int k = 0; k < 16; k++) line[8*k +: 8] = bytes[16*l + k];
      e.addr = 9'(l);
      e.data = line;
      exp_q.push_back(e);
    end
    tr = bad_tr ? (sum ^ 32'h0100_0000) : sum;

    busy_cycles = 0;
    n_writes    = 0;
    start       = 1'b1;
    len_lines   = 10'(len);
    cyc();
    start   = 1'b0;
    e_done  = 1'b0;
    e_err   = 1'b0;
    e_busy  = (eff != 0) || CSUM;
    e_ready = (eff != 0) || CSUM;
    if (eff == 0 && !CSUM) e_done = 1'b1;

    for (int i = 0; i < eff * 16; i++) begin
      send_byte(bytes[i], gap, i == poke_at);
      if (i == abort_at) return;
      if (i % 16 == 15) begin
        e_ready  = 1'b0;
        e_we     = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        cyc();
        in_valid = 1'b0;
        e_we     = 1'b0;
        if (i == eff * 16 - 1) begin
          if (CSUM) e_ready = 1'b1;
          else begin
            e_busy = 1'b0;
            e_done = 1'b1;
          end
        end else begin
          e_ready = 1'b1;
        end
      end
    end

    if (CSUM) begin
      for (int k = 0; k < 4; k++) send_byte(tr[8*k +: 8], gap, 1'b0);
      e_busy  = 1'b0;
      e_ready = 1'b0;
      e_done  = 1'b1;
      e_err   = (tr != sum);
    end
    cyc();
    cyc();
    check("writes_pending", 128'(exp_q.size()), 0);
  endtask

  initial begin
    repeat (3) cyc();
    check_reset_outputs("reset");
    reset_x = 1'b1;
    chk_en  = 1'b1;
    cyc();

    // One line of 0x00..0x0F, no gaps
    do_load(1, 0, 1, 1'b0, -1, -1);
    check("l1_data", last_data, 128'h0F0E0D0C0B0A09080706050403020100);
    check("l1_addr", last_addr, 0);
    check("l1_nwr", n_writes, 1);
    check("l1_busy", busy_cycles, CSUM ? 21 : 17);

    // Two lines with idle gaps on the stream
    do_load(2, 50, 0, 1'b0, -1, -1);
    check("l2_nwr", n_writes, 2);
    check("l2_addr", last_addr, 1);

    // Oversized request clamps to the memory depth
    do_load(600, 0, 0, 1'b0, -1, -1);
    check("l600_nwr", n_writes, 512);
    check("l600_addr", last_addr, 511);
    check("l600_busy", busy_cycles, CSUM ? 512*17 + 4 : 512*17);

    // Empty load
    do_load(0, 0, 0, 1'b0, -1, -1);
    check("l0_nwr", n_writes, 0);
    check("l0_busy", busy_cycles, CSUM ? 4 : 0);
    check("l0_err", err, 0);

    // Known word sum 0x12345678 with a wrong and a correct trailer
    do_load(1, 0, 2, 1'b1, -1, -1);
    check("csum_bad_err", err, CSUM ? 1 : 0);
    do_load(1, 0, 2, 1'b0, -1, -1);
    check("csum_ok_err", err, 0);

    // Start pulse (with len 0) while busy must be ignored
    do_load(3, 20, 0, 1'b0, -1, 5);
    check("poke_nwr", n_writes, 3);

    // Reset after 8 bytes of line 3
    do_load(4, 0, 0, 1'b0, 3*16 + 7, -1);
    check("abort_nwr", n_writes, 3);
    reset_x = 1'b0;
    #1;
    check_reset_outputs("midreset");
    e_busy  = 1'b0;
    e_ready = 1'b0;
    e_we    = 1'b0;
    e_done  = 1'b0;
    e_err   = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    reset_x = 1'b1;
    cyc();
    do_load(1, 0, 0, 1'b0, -1, -1);
    check("post_reset_addr", last_addr, 0);
    check("post_reset_nwr", n_writes, 1);

    // Random short loads with random gaps
    for (int r = 0; r < 6; r++) begin
      do_load(int'($urandom_range(1, 5)), int'($urandom_range(0, 60)), 0, 1'($urandom), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
